// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the VGA timing outputs that go to the DAC and the pixel pipeline.
//
//   pixel_clk   : 25 MHz pixel clock for the DAC (Clk/2)
//   pixel_en    : one-Clk enable, high in the cycle before the counters advance
//   hs, vs      : horizontal / vertical sync, active-low
//   blank_n     : 1 inside the visible region
//   DrawX/DrawY : current horizontal / vertical counter values
//   frame_start : one-Clk pulse when the counters have wrapped to (0,0)
//
//   master : the timing generator (drives everything)
//   slave  : background / sprite / colour-mapper / DAC consumers
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface vga_timing_gen_if;
  logic       pixel_clk;
  logic       pixel_en;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;

  modport master (
    output pixel_clk, pixel_en, hs, vs, blank_n, DrawX, DrawY, frame_start
  );

  modport slave (
    input pixel_clk, pixel_en, hs, vs, blank_n, DrawX, DrawY, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 Hz VGA timing generator running from the 50 MHz system clock.
//   A toggle flop divides Clk by two; on every second Clk the pixel counters
//   advance. Sync, blank and frame_start are registered from the *next*
//   counter values so they line up with DrawX/DrawY in the same cycle.
//
//   Ports
//     Clk   : 50 MHz system clock
//     Reset : asynchronous, active-high reset
//     vga   : vga_timing_gen_if.master (pixel_clk, pixel_en, hs, vs,
//             blank_n, DrawX, DrawY, frame_start)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              Clk,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       t_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_n_q, blank_n_d;
  logic       frame_start_q;
  logic       frame_wrap_d;

  // Next counter position and the sync/blank levels that belong to it.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_wrap_d = 1'b0;
    if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d          = '0;
        frame_wrap_d = 1'b1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
    end

    hs_d      = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d      = !((y_d >= VS_START) && (y_d < VS_END));
    blank_n_d = (x_d < H_VIS_END) && (y_d < V_VIS_END);
  end

  // t_q doubles as pixel_clk and pixel_en: the counters advance on the edge
  // that ends a cycle in which t_q is high. frame_start is cleared on the
  // following (non-advancing) edge, so it is exactly one Clk wide.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      t_q           <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      t_q           <= ~t_q;
      frame_start_q <= 1'b0;
      if (t_q) begin
        x_q           <= x_d;
        y_q           <= y_d;
        hs_q          <= hs_d;
        vs_q          <= vs_d;
        blank_n_q     <= blank_n_d;
        frame_start_q <= frame_wrap_d;
      end
    end
  end

  assign vga.pixel_clk   = t_q;
  assign vga.pixel_en    = t_q;
  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank_n     = blank_n_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #10 Clk = ~Clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen dut_a (
    .Clk   (Clk),
    .Reset (rst_a),
    .vga   (if_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) dut_b (
    .Clk   (Clk),
    .Reset (rst_b),
    .vga   (if_b)
  );

  int checks = 0;
  int errors = 0;

  // Expected view after an advance: {pixel_en, DrawX, DrawY, hs, vs, blank_n, frame_start}
  logic [24:0] qa[$];
  logic [24:0] qb[$];

  // {pixel_clk, pixel_en, DrawX, DrawY, hs, vs, blank_n, frame_start}
  localparam logic [25:0] RST_VAL = {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference position after k pixel enables since reset.
  function automatic logic [24:0] model(input int k, input int hv, input int hf, input int hsw,
                                        input int hb, input int vv, input int vf, input int vsw,
                                        input int vb);
    int   ht, vt, x, y;
    logic h, v, b, f;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    x  = k % ht;
    y  = (k / ht) % vt;
    h  = !((x >= hv + hf) && (x < hv + hf + hsw));
    v  = !((y >= vv + vf) && (y < vv + vf + vsw));
    b  = (x < hv) && (y < vv);
    f  = (k > 0) && ((k % (ht * vt)) == 0);
    return {1'b0, 10'(x), 10'(y), h, v, b, f};
  endfunction

  // ---------------- monitors ----------------
  logic        pe_prev_a = 1'b0;
  logic        pe_prev_b = 1'b0;
  logic [24:0] exp_a, exp_b;

  always @(negedge Clk) begin
    if (rst_a) begin
      pe_prev_a <= 1'b0;
    end else begin
      if (qa.size() > 0) begin
        if (pe_prev_a) begin
          exp_a = qa.pop_front();
          check("A pixel", 64'({if_a.pixel_en, if_a.DrawX, if_a.DrawY, if_a.hs, if_a.vs,
                                if_a.blank_n, if_a.frame_start}), 64'(exp_a));
        end else begin
          check("A fs idle", 64'(if_a.frame_start), 64'(0));
        end
      end
      pe_prev_a <= if_a.pixel_en;
    end
  end

  always @(negedge Clk) begin
    if (rst_b) begin
      pe_prev_b <= 1'b0;
    end else begin
      if (qb.size() > 0) begin
        if (pe_prev_b) begin
          exp_b = qb.pop_front();
          check("B pixel", 64'({if_b.pixel_en, if_b.DrawX, if_b.DrawY, if_b.hs, if_b.vs,
                                if_b.blank_n, if_b.frame_start}), 64'(exp_b));
        end else begin
          check("B fs idle", 64'(if_b.frame_start), 64'(0));
        end
      end
      pe_prev_b <= if_b.pixel_en;
    end
  end

  // Period between frame_start pulses on the small-geometry DUT: 60 px * 2 Clk.
  int clk_cnt = 0;
  int last_fs = -1;
  always @(posedge Clk) clk_cnt <= clk_cnt + 1;
  always @(negedge Clk) begin
    if (rst_b) begin
      last_fs <= -1;
    end else if (if_b.frame_start) begin
      if (last_fs >= 0) check("B frame period", 64'(clk_cnt - last_fs), 64'(120));
      last_fs <= clk_cnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    #1;
    check("A reset", 64'({if_a.pixel_clk, if_a.pixel_en, if_a.DrawX, if_a.DrawY, if_a.hs,
                          if_a.vs, if_a.blank_n, if_a.frame_start}), 64'(RST_VAL));
    check("B reset", 64'({if_b.pixel_clk, if_b.pixel_en, if_b.DrawX, if_b.DrawY, if_b.hs,
                          if_b.vs, if_b.blank_n, if_b.frame_start}), 64'(RST_VAL));

    // Default geometry: two full lines plus a few pixels of the third.
    for (int k = 1; k <= 1610; k++) qa.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33));
    #2 rst_a = 1'b0;
    @(negedge Clk);
    check("A first pe", 64'({if_a.pixel_en, if_a.DrawX}), 64'({1'b1, 10'd0}));
    @(negedge Clk);
    check("A after pe", 64'({if_a.pixel_en, if_a.DrawX}), 64'({1'b0, 10'd1}));
    for (int i = 0; i < 5000 && qa.size() > 0; i++) @(negedge Clk);
    check("A drain", 64'(qa.size()), 64'(0));
    rst_a = 1'b1;

    // Small geometry: two frames, then up to (5,3) of the third.
    for (int k = 1; k <= 161; k++) qb.push_back(model(k, 8, 1, 2, 1, 2, 1, 1, 1));
    @(negedge Clk);
    #2 rst_b = 1'b0;
    @(negedge Clk);
    check("B first pe", 64'({if_b.pixel_en, if_b.DrawX}), 64'({1'b1, 10'd0}));
    for (int i = 0; i < 1000 && qb.size() > 0; i++) @(negedge Clk);
    check("B drain 1", 64'(qb.size()), 64'(0));
    check("B pre-abort pos", 64'({if_b.DrawX, if_b.DrawY}), 64'({10'd5, 10'd3}));

    // Abort mid-frame between edges; outputs must clear without a Clk edge.
    #3 rst_b = 1'b1;
    #1;
    check("B async reset", 64'({if_b.pixel_clk, if_b.pixel_en, if_b.DrawX, if_b.DrawY, if_b.hs,
                                if_b.vs, if_b.blank_n, if_b.frame_start}), 64'(RST_VAL));
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    for (int k = 1; k <= 130; k++) qb.push_back(model(k, 8, 1, 2, 1, 2, 1, 1, 1));
    #2 rst_b = 1'b0;
    @(negedge Clk);
    check("B restart pe", 64'({if_b.pixel_en, if_b.DrawX, if_b.DrawY, if_b.frame_start}),
          64'({1'b1, 10'd0, 10'd0, 1'b0}));
    for (int i = 0; i < 1000 && qb.size() > 0; i++) @(negedge Clk);
    check("B drain 2", 64'(qb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock using an internal divide-by-2 pixel enable.
- Produces the DrawX/DrawY pixel coordinates that are consumed by the background, sprite and colour-mapper stages.
- Produces HS/VS/blank for the DAC and a frame_start strobe that the game-state logic uses for once-per-frame updates.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
- Clk, input, 1, 50 MHz system clock
- Reset, input, 1, asynchronous, active-high reset
- pixel_clk, output, 1, 25 MHz pixel clock to the DAC (Clk/2, registered toggle)
- pixel_en, output, 1, one-Clk-wide enable; high on the Clk cycle in which the counters advance
- hs, output, 1, horizontal sync, active-low
- vs, output, 1, vertical sync, active-low
- blank_n, output, 1, 1 = visible region, 0 = blanking
- DrawX, output, 10, current horizontal counter (0..H_TOTAL-1)
- DrawY, output, 10, current vertical counter (0..V_TOTAL-1)
- frame_start, output, 1, one-Clk pulse when the counters wrap to (0,0)

Behaviour:
- Reset (async, active-high), all outputs:
  - pixel_clk=0, pixel_en=0, DrawX=0, DrawY=0
  - hs=1, vs=1, blank_n=0, frame_start=0
  - Reset asserted mid-frame aborts the frame immediately; the first frame after release starts cleanly at (0,0).
- Pixel enable:
  - Internal toggle flop t; pixel_clk = t.
  - pixel_en = 1 on the Clk cycle in which t is 1, so it asserts every second Clk.
  - The first pixel_en occurs on the 2nd rising edge after Reset deasserts.
- Counters (update only on Clk edges where pixel_en=1):
  - DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps to 0 after V_TOTAL-1, which happens on the same edge that DrawX wraps.
  - Counters never exceed 799/524. The counters are 10 bits and no overflow is possible.
- Sync/blank (registered, computed from the next counter values so they are aligned with DrawX/DrawY on the same cycle):
  - hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - blank_n = 1 iff DrawX < 640 and DrawY < 480.
  - vs changes only on the line-wrap edge. No glitches on any output (all driven from flops).
- frame_start:
  - 1 for exactly one Clk cycle, on the cycle in which the counters have just become (0,0) via wrap.
  - Not asserted on the initial (0,0) after reset; the first pulse comes after the first complete frame.
- Timing summary:
  - line = 800 pixel_en = 1600 Clk
  - frame = 420000 pixel_en = 840000 Clk
- Downstream contract:
  - The address-generating stages are combinational on DrawX/DrawY. Any ROM stage with 1-cycle latency is aligned by the colour mapper, not by this block.
  - Consumers must mask pixels with blank_n. DrawX/DrawY outside the visible area are still valid counter values.

Test Plan:
- Reset release: hold Reset 5 Clk then release -> all outputs at reset values; first pixel_en at Clk 2, DrawX=1 after it.
- Line wrap: run to DrawX=799 -> next pixel_en gives DrawX=0 and DrawY+1; hs=0 for exactly DrawX 656..751 (96 pixel_en = 192 Clk); blank_n falls at DrawX=640.
- Frame wrap: run to (799,524) -> next pixel_en gives (0,0) and frame_start=1 for one Clk; the interval between consecutive frame_start pulses is exactly 840000 Clk.
- Vertical sync: vs=0 from the start of DrawY=490 through the end of DrawY=491 (1600 pixel_en); blank_n=0 for all of DrawY 480..524.
- Async reset mid-frame: assert Reset at (300,200) between edges -> outputs return to reset values without waiting for Clk; after release the count restarts at (0,0) with no frame_start.
- Parameter override: set H_VISIBLE=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_*=2,1,1,1 -> hs low at DrawX 9..10, DrawX wraps after 11, DrawY wraps after 4.
